// File: rtl/mem_lat_pkg.sv
// Shared definitions for the latency-modelling memory slave.
//   - LAT_W      : width of the latency configuration and wait counter
//   - LFSR_TAPS  : feedback taps of the 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1)
//   - state_t    : 2-bit FSM state encoding with its four state constants
//   - lfsr_next  : single LFSR step, shared so every user agrees on the sequence
package mem_lat_pkg;

  localparam int unsigned LAT_W = 5;

  // Shift-left Fibonacci form: bit 7 is the x^8 term, bits 5/4/3 are x^6/x^5/x^4.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  typedef logic [1:0] state_t;

  localparam state_t StIdle   = 2'd0;
  localparam state_t StWait   = 2'd1;
  localparam state_t StAccess = 2'd2;
  localparam state_t StResp   = 2'd3;

  function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
    return {cur[6:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/mem_lat_slave_lfsr8.sv
// 8-bit free-running Fibonacci LFSR used to draw pseudo-random latencies.
// Ports:
//   clk    in   clock
//   rst_n  in   asynchronous active-low reset, loads SEED
//   q      out  current LFSR state
// SEED must be nonzero; an all-zero state would lock the register.
module lfsr8
  import mem_lat_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [7:0] q
);

  logic [7:0] q_q;
  logic [7:0] q_d;

  always_comb begin
    q_d = lfsr_next(q_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= SEED;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/mem_lat_slave.sv
// Memory-side slave for the npc fetch/load-store path.
// Takes one valid/ready request, waits a fixed or pseudo-random number of
// cycles, performs a single access on a synchronous-read SRAM port and holds
// the response until the consumer accepts it. One request outstanding at most.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready        request handshake
//   req_wen, req_addr,
//   req_wdata, req_wmask       request payload (sampled only at the handshake)
//   rsp_valid/rsp_ready        response handshake
//   rsp_rdata, rsp_err         response payload (rdata is 0 for writes/errors)
//   cfg_lat, cfg_rand_en       fixed latency, or mask applied to LFSR bits
//   mem_en, mem_we, mem_idx,
//   mem_wdata, mem_wmask       SRAM command, driven during the access cycle
//   mem_rdata                  SRAM read data, valid the cycle after a read
module mem_lat_slave
  import mem_lat_pkg::*;
#(
  parameter logic [31:0]  ADDR_BASE = 32'h8000_0000,
  parameter int unsigned  MEM_WORDS = 4096,
  parameter logic [7:0]   LFSR_SEED = 8'hA5,
  localparam int unsigned IDX_W     = $clog2(MEM_WORDS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_wen,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  input  logic [3:0]       req_wmask,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_rdata,
  output logic             rsp_err,
  input  logic [LAT_W-1:0] cfg_lat,
  input  logic             cfg_rand_en,
  output logic             mem_en,
  output logic             mem_we,
  output logic [IDX_W-1:0] mem_idx,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_wmask,
  input  logic [31:0]      mem_rdata
);

  // 33-bit bounds so that ADDR_BASE + 4*MEM_WORDS cannot wrap past 2^32.
  localparam logic [32:0] BaseExt = {1'b0, ADDR_BASE};
  localparam logic [32:0] LimExt  = BaseExt + (33'(MEM_WORDS) << 2);

  // ---------------------------------------------------------------------------
  // Latency source
  // ---------------------------------------------------------------------------
  logic [7:0] lfsr_q;

  lfsr8 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .q     (lfsr_q)
  );

  logic [LAT_W-1:0] lat_sel;

  always_comb begin
    lat_sel = cfg_rand_en ? (lfsr_q[LAT_W-1:0] & cfg_lat) : cfg_lat;
  end

  // ---------------------------------------------------------------------------
  // Request address decode
  // ---------------------------------------------------------------------------
  logic [32:0]      addr_ext;
  logic [31:0]      addr_off;
  logic             req_err;
  logic [IDX_W-1:0] req_idx;
  logic             unused_bits;

  always_comb begin
    addr_ext = {1'b0, req_addr};
    addr_off = req_addr - ADDR_BASE;
    req_err  = (req_addr[1:0] != 2'b00) || (addr_ext < BaseExt) || (addr_ext >= LimExt);
    req_idx  = addr_off[IDX_W+1:2];
  end

  // Offset bits outside the word index only matter through req_err.
  assign unused_bits = ^{addr_off[31:IDX_W+2], addr_off[1:0], lfsr_q[7:LAT_W]};

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t           state_q,     state_d;
  logic [LAT_W-1:0] cnt_q,       cnt_d;
  logic             wen_q,       wen_d;
  logic             err_q,       err_d;
  logic [IDX_W-1:0] idx_q,       idx_d;
  logic [31:0]      wdata_q,     wdata_d;
  logic [3:0]       wmask_q,     wmask_d;
  logic [31:0]      rsp_rdata_q, rsp_rdata_d;
  logic             rsp_err_q,   rsp_err_d;
  logic             rsp_first_q, rsp_first_d;

  // SRAM read data only becomes available in the first RESP cycle, so it is
  // forwarded straight through in that cycle and held in rsp_rdata_q after.
  logic [31:0] rd_sel;

  always_comb begin
    rd_sel = (!wen_q && !err_q) ? mem_rdata : 32'h0;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wen_d       = wen_q;
    err_d       = err_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    wmask_d     = wmask_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    rsp_first_d = 1'b0;

    case (state_q)
      StIdle: begin
        if (req_valid) begin
          wen_d   = req_wen;
          err_d   = req_err;
          idx_d   = req_idx;
          wdata_d = req_wdata;
          wmask_d = req_wmask;
          if (lat_sel == '0) begin
            state_d = StAccess;
          end else begin
            cnt_d   = lat_sel;
            state_d = StWait;
          end
        end
      end

      // Counter is loaded with lat, so WAIT lasts exactly lat cycles.
      StWait: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == LAT_W'(1)) begin
          state_d = StAccess;
        end
      end

      StAccess: begin
        rsp_err_d   = err_q;
        rsp_first_d = 1'b1;
        state_d     = StResp;
      end

      StResp: begin
        if (rsp_first_q) begin
          rsp_rdata_d = rd_sel;
        end
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      wen_q       <= 1'b0;
      err_q       <= 1'b0;
      idx_q       <= '0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_first_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wen_q       <= wen_d;
      err_q       <= err_d;
      idx_q       <= idx_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      rsp_first_q <= rsp_first_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    req_ready = (state_q == StIdle);
    rsp_valid = (state_q == StResp);
    rsp_rdata = rsp_first_q ? rd_sel : rsp_rdata_q;
    rsp_err   = rsp_err_q;
    // Faulting requests keep their timing but never touch the SRAM.
    mem_en    = (state_q == StAccess) && !err_q;
    mem_we    = (state_q == StAccess) && !err_q && wen_q;
    mem_idx   = idx_q;
    mem_wdata = wdata_q;
    mem_wmask = wmask_q;
  end

endmodule

// File: tb/tb_mem_lat_slave.sv
module tb_mem_lat_slave;

  localparam int unsigned MemWords = 4096;
  localparam logic [31:0] Base     = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wen = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_wmask = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [4:0]  cfg_lat = '0;
  logic        cfg_rand_en = 1'b0;
  logic        mem_en;
  logic        mem_we;
  logic [11:0] mem_idx;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_rdata;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_lat_slave dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_wen     (req_wen),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_wmask   (req_wmask),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .cfg_lat     (cfg_lat),
    .cfg_rand_en (cfg_rand_en),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_idx     (mem_idx),
    .mem_wdata   (mem_wdata),
    .mem_wmask   (mem_wmask),
    .mem_rdata   (mem_rdata)
  );

  // Synchronous-read SRAM with a backdoor port for preloading.
  logic [31:0] sram [MemWords];
  logic        bd_clr = 1'b0;
  logic        bd_we = 1'b0;
  logic [11:0] bd_idx = '0;
  logic [31:0] bd_data = '0;
  int          en_cnt = 0;
  int          we_cnt = 0;
  int          cyc = 0;

  always @(posedge clk) begin
    if (bd_clr) begin
      for (int i = 0; i < int'(MemWords); i++) sram[i] <= '0;
    end else if (bd_we) begin
      sram[bd_idx] <= bd_data;
    end else if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_wmask[b]) sram[mem_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
      end else begin
        mem_rdata <= sram[mem_idx];
      end
    end
  end

  always @(posedge clk) begin
    if (mem_en) en_cnt <= en_cnt + 1;
    if (mem_we) we_cnt <= we_cnt + 1;
  end

  // Clock edges seen since reset release: indexes the reference LFSR sequence.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Reference model state
  logic [31:0] ref_mem [MemWords];

  function automatic logic [7:0] lfsr_after(input int n);
    logic [7:0] s;
    s = 8'hA5;
    for (int i = 0; i < n; i++) s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    return s;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Request ports carry junk outside the IDLE handshake; the DUT must ignore it.
  task automatic garbage();
    req_valid   = 1'($urandom_range(0, 1));
    req_wen     = 1'($urandom_range(0, 1));
    req_addr    = $urandom;
    req_wdata   = $urandom;
    req_wmask   = 4'($urandom);
    cfg_lat     = 5'($urandom);
    cfg_rand_en = 1'($urandom_range(0, 1));
  endtask

  task automatic do_req(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wmask, input logic [4:0] lat_cfg, input logic rnd,
                        input int hold);
    logic [7:0]  l;
    logic [4:0]  lat;
    logic        err;
    logic [31:0] exp_rd;
    logic [31:0] h_rd;
    logic        h_err;
    int          idx;
    int          en0;
    int          we0;
    int          k;
    l      = lfsr_after(cyc);
    lat    = rnd ? (l[4:0] & lat_cfg) : lat_cfg;
    err    = (addr[1:0] != 2'b00) || (addr < Base) ||
             ({1'b0, addr} >= ({1'b0, Base} + 33'(4 * MemWords)));
    idx    = err ? 0 : int'((addr - Base) >> 2);
    exp_rd = (!wen && !err) ? ref_mem[idx] : 32'h0;
    if (wen && !err) begin
      for (int b = 0; b < 4; b++) if (wmask[b]) ref_mem[idx][8*b +: 8] = wdata[8*b +: 8];
    end
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid   = 1'b1;
    req_wen     = wen;
    req_addr    = addr;
    req_wdata   = wdata;
    req_wmask   = wmask;
    cfg_lat     = lat_cfg;
    cfg_rand_en = rnd;
    en0 = en_cnt;
    we0 = we_cnt;
    k = 0;
    while (!rsp_valid && k < 40) begin
      step();
      garbage();
      k++;
    end
    check("latency", 32'(k), 32'(lat) + 32'd2);
    check("latency_range", 32'(k >= 2 && k <= 33), 32'd1);
    check("rsp_valid", 32'(rsp_valid), 32'd1);
    check("rsp_rdata", rsp_rdata, exp_rd);
    check("rsp_err", 32'(rsp_err), 32'(err));
    check("req_ready_busy", 32'(req_ready), 32'd0);
    h_rd  = exp_rd;
    h_err = err;
    for (int i = 0; i < hold; i++) begin
      step();
      garbage();
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_rdata", rsp_rdata, h_rd);
      check("hold_err", 32'(rsp_err), 32'(h_err));
      check("hold_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("req_ready_after", 32'(req_ready), 32'd1);
    check("rsp_valid_after", 32'(rsp_valid), 32'd0);
    check("mem_en_pulses", 32'(en_cnt - en0), err ? 32'd0 : 32'd1);
    check("mem_we_pulses", 32'(we_cnt - we0), (wen && !err) ? 32'd1 : 32'd0);
  endtask

  int          pool [16];
  logic [31:0] a;
  int          seen;
  int          we0;

  initial begin
    for (int i = 0; i < int'(MemWords); i++) ref_mem[i] = '0;

    // Reset and clear the SRAM model
    bd_clr = 1'b1;
    step();
    step();
    bd_clr = 1'b0;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    bd_we   = 1'b1;
    bd_idx  = 12'd0;
    bd_data = 32'hDEAD_BEEF;
    ref_mem[0] = 32'hDEAD_BEEF;
    step();
    bd_we = 1'b0;
    rst_n = 1'b1;
    step();

    // Fixed-latency read
    do_req(1'b0, 32'h8000_0000, '0, '0, 5'd3, 1'b0, 0);

    // Zero-latency masked write, then read-back
    do_req(1'b1, 32'h8000_0010, 32'h1122_3344, 4'b0101, 5'd0, 1'b0, 0);
    do_req(1'b0, 32'h8000_0010, '0, '0, 5'd0, 1'b0, 0);
    check("readback_const", ref_mem[4], 32'h0022_0044);

    // Faulting addresses, including the first word past the top and a faulting write
    do_req(1'b0, 32'h8000_0002, '0, '0, 5'd2, 1'b0, 0);
    do_req(1'b0, 32'h7FFF_FFFC, '0, '0, 5'd2, 1'b0, 0);
    do_req(1'b0, 32'h8000_4000, '0, '0, 5'd1, 1'b0, 0);
    do_req(1'b0, 32'hFFFF_FFFC, '0, '0, 5'd0, 1'b0, 0);
    do_req(1'b1, 32'h8000_4000, 32'hCAFE_F00D, 4'hF, 5'd2, 1'b0, 0);

    // Top legal word, write and read back
    do_req(1'b1, 32'h8000_3FFC, 32'hA5A5_5A5A, 4'hF, 5'd1, 1'b0, 0);
    do_req(1'b0, 32'h8000_3FFC, '0, '0, 5'd1, 1'b0, 0);

    // Zero-mask write still strobes the SRAM but leaves the word untouched
    do_req(1'b1, 32'h8000_0010, 32'hFFFF_FFFF, 4'h0, 5'd1, 1'b0, 0);
    do_req(1'b0, 32'h8000_0010, '0, '0, 5'd0, 1'b0, 0);

    // Backpressure
    do_req(1'b0, 32'h8000_0000, '0, '0, 5'd4, 1'b0, 10);

    // Random writes to a pool of words
    for (int i = 0; i < 16; i++) begin
      pool[i] = int'($urandom_range(0, MemWords - 1));
      do_req(1'b1, Base + 32'(pool[i]) * 4, $urandom, 4'($urandom), 5'($urandom_range(0, 3)),
             1'b0, int'($urandom_range(0, 2)));
    end

    // Random-latency reads over the full mask, with occasional faults
    for (int i = 0; i < 200; i++) begin
      a = Base + 32'(pool[$urandom_range(0, 15)]) * 4;
      if ($urandom_range(0, 9) == 0) a = a + 32'($urandom_range(1, 3));
      do_req(1'b0, a, '0, '0, 5'h1F, 1'b1, 0);
    end

    // Random mode with random masks, including a zero mask
    do_req(1'b0, Base + 32'(pool[0]) * 4, '0, '0, 5'd0, 1'b1, 0);
    for (int i = 0; i < 20; i++) begin
      do_req(1'b0, Base + 32'(pool[i % 16]) * 4, '0, '0, 5'($urandom), 1'b1, 0);
    end

    // Reset while a write sits in WAIT
    we0 = we_cnt;
    req_valid = 1'b1;
    req_wen   = 1'b1;
    req_addr  = 32'h8000_0020;
    req_wdata = 32'h55AA_55AA;
    req_wmask = 4'hF;
    cfg_lat   = 5'd10;
    cfg_rand_en = 1'b0;
    step();
    req_valid = 1'b0;
    step();
    step();
    step();
    rst_n = 1'b0;
    #1;
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst_req_ready", 32'(req_ready), 32'd1);
    check("midrst_mem_en", 32'(mem_en), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (rsp_valid) seen++;
    end
    check("midrst_no_rsp", 32'(seen), 32'd0);
    check("midrst_no_write", 32'(we_cnt - we0), 32'd0);
    do_req(1'b0, 32'h8000_0020, '0, '0, 5'd3, 1'b0, 0);
    do_req(1'b0, 32'h8000_0000, '0, '0, 5'h1F, 1'b1, 2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
